issue_ctrl: RTL and testbench
=============================

Name: issue_ctrl

Overview:
- Dual-issue in-order scheduler between the instruction decoder and the execution units.
- Holds one decoded instruction pair and tracks pending destination registers in a scoreboard.
- Each cycle it issues zero, one or two instructions to the ALU unit (add, branch) and the MEM unit (load, store), stalling on data hazards and structural conflicts.

Parameters:
- NREG, 16, architectural register count; REG_W = log2(NREG)
- REG_W, 4, register index width
- OP_W, 4, opcode width
- IMM_W, 5, immediate width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard the held pair; the scoreboard is kept
- in_valid  in  1  decoded pair present
- in_ready  out  1  pair buffer can accept
- ins_1_op / ins_2_op  in  OP_W  opcode of slot 1 / slot 2 (older = slot 1)
- ins_1_des / ins_2_des  in  REG_W  destination (0 = none)
- ins_1_s1 / ins_2_s1  in  REG_W  source 1
- ins_1_s2 / ins_2_s2  in  REG_W  source 2
- ins_1_ime / ins_2_ime  in  IMM_W  immediate
- alu_ready  in  1  ALU can take an instruction this cycle
- mem_ready  in  1  MEM can take an instruction this cycle
- wb0_valid, wb1_valid  in  1  writeback completions
- wb0_reg, wb1_reg  in  REG_W  registers written back
- alu_valid  out  1  registered ALU issue strobe
- alu_op, alu_des, alu_s1, alu_s2, alu_imm  out  OP_W/REG_W/REG_W/REG_W/IMM_W  issued ALU fields
- mem_valid  out  1  registered MEM issue strobe
- mem_op, mem_des, mem_s1, mem_s2, mem_imm  out  as for the ALU fields  issued MEM fields
- illegal_op  out  1  registered pulse: an unknown opcode was dropped
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Opcodes:
  - 1000 add → ALU
  - 0001 branch → ALU
  - 0100 load → MEM
  - 0010 store → MEM
  - Any other opcode is illegal: it is consumed without issue, illegal_op pulses, and it counts as "issued" for ordering purposes.
- Reset:
  - Buffer state EMPTY; busy[NREG-1:0] = 0.
  - All *_valid outputs, illegal_op and stall_cnt = 0; all issued field outputs = 0.
- Buffer FSM:
  - EMPTY: in_ready = 1. in_valid → latch both slots → FULL.
  - FULL: in_ready = 0.
    - Both slots issue → EMPTY.
    - Only slot 1 issues → SLOT2.
    - Neither issues → stay.
  - SLOT2: in_ready = 0. Slot 2 is treated as the oldest. If it issues → EMPTY.
  - flush in any state → EMPTY next cycle with no issue that cycle; flush has priority over in_valid and over issue.
- Hazards (slot X, checked against the registered busy only, with no writeback bypass):
  - Stall if busy[sX1], busy[sX2], or busy[desX] with desX != 0.
  - Register 0 is never marked busy.
- Issue rules:
  - The oldest valid slot issues when it has no hazard and its unit's ready is 1.
  - Slot 2 issues in the same cycle only if all of the following hold:
    - slot 1 also issues;
    - the two slots target different units;
    - slot 2 has no hazard;
    - ins_1_des == 0, or ins_1_des differs from ins_2_s1, ins_2_s2 and ins_2_des.
  - Never out of order: slot 2 never issues ahead of slot 1.
- Timing:
  - Issue decision is combinational; the outputs are registered.
  - Pair accepted at edge t; earliest alu_valid/mem_valid high after edge t+1.
  - Each strobe is high for exactly one cycle per issued instruction.
- Scoreboard:
  - Issue of add or load with des != 0 sets busy[des] at the decision edge.
  - wb0/wb1 clear busy[reg]; wb with reg 0 is ignored.
  - Set and clear of the same register on the same edge → set wins.
- stall_cnt: +1 each cycle the buffer is non-EMPTY, flush = 0, and nothing issues; saturates at all-ones.
- rst mid-operation: the buffer and scoreboard are discarded and any in-flight strobes drop to 0 on the next edge.

Test Plan:
- Pair add r1=r2+r3, load r4=[r5+3], all ready, busy clear → next edge alu_valid & mem_valid both 1 with the exact fields; busy[1] and busy[4] set; state EMPTY.
- Pair add r1=r2+r3, add r6=r1+r1 → slot 1 issues, slot 2 held (same unit and RAW); slot 2 stays held until wb0 r1; slot 2 issues the cycle after that writeback.
- Pair load r2, store [r7]=r2 (different units, RAW on r2) → only the load issues; stall_cnt increments while r2 is busy.
- mem_ready=0 for 3 cycles with a load in slot 1 and an add in slot 2 → no issue (in-order), stall_cnt=3; mem_ready=1 → both issue together.
- Opcode 1111 in slot 1 with an add in slot 2 → illegal_op pulses, the add issues on the ALU, no busy bit set for slot 1.
- flush asserted while FULL, and rst asserted while busy[5]=1 → state EMPTY with no strobes; after rst, busy=0 and stall_cnt=0.

Source files
------------

// File: rtl/issue_ctrl.sv
// Dual-issue in-order scheduler: holds one decoded pair, tracks pending
// destinations in a busy scoreboard and issues to the ALU and MEM units.
module issue_ctrl #(
   parameter int unsigned NREG  = 16,
   parameter int unsigned REG_W = $clog2(NREG),
   parameter int unsigned OP_W  = 4,
   parameter int unsigned IMM_W = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  ins_1_op,
   input  logic [REG_W-1:0] ins_1_des,
   input  logic [REG_W-1:0] ins_1_s1,
   input  logic [REG_W-1:0] ins_1_s2,
   input  logic [IMM_W-1:0] ins_1_ime,
   input  logic [OP_W-1:0]  ins_2_op,
   input  logic [REG_W-1:0] ins_2_des,
   input  logic [REG_W-1:0] ins_2_s1,
   input  logic [REG_W-1:0] ins_2_s2,
   input  logic [IMM_W-1:0] ins_2_ime,
   input  logic             alu_ready,
   input  logic             mem_ready,
   input  logic             wb0_valid,
   input  logic [REG_W-1:0] wb0_reg,
   input  logic             wb1_valid,
   input  logic [REG_W-1:0] wb1_reg,
   output logic             alu_valid,
   output logic [OP_W-1:0]  alu_op,
   output logic [REG_W-1:0] alu_des,
   output logic [REG_W-1:0] alu_s1,
   output logic [REG_W-1:0] alu_s2,
   output logic [IMM_W-1:0] alu_imm,
   output logic             mem_valid,
   output logic [OP_W-1:0]  mem_op,
   output logic [REG_W-1:0] mem_des,
   output logic [REG_W-1:0] mem_s1,
   output logic [REG_W-1:0] mem_s2,
   output logic [IMM_W-1:0] mem_imm,
   output logic             illegal_op,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [OP_W-1:0] OP_ADD = OP_W'(8);
   localparam logic [OP_W-1:0] OP_BR  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_LD  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_ST  = OP_W'(2);

   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SLOT2 = 2'd2} state_t;

   state_t state, state_d;

   logic [OP_W-1:0]  slot1_op, slot2_op;
   logic [REG_W-1:0] slot1_des, slot1_s1, slot1_s2;
   logic [REG_W-1:0] slot2_des, slot2_s1, slot2_s2;
   logic [IMM_W-1:0] slot1_imm, slot2_imm;
   logic [NREG-1:0]  busy, set_mask, clr_mask;

   logic [OP_W-1:0]  old_op;
   logic [REG_W-1:0] old_des, old_s1, old_s2;
   logic [IMM_W-1:0] old_imm;
   logic old_alu, old_mem, old_ill, old_haz, old_go;
   logic yng_alu, yng_mem, yng_ill, yng_haz, yng_go, dep_ok;
   logic alu_go_c, mem_go_c, ill_c, stall_c, load_c, alu_old_c, mem_old_c;

   function automatic logic is_alu(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_BR);
   endfunction

   function automatic logic is_mem(input logic [OP_W-1:0] op);
      return (op == OP_LD) || (op == OP_ST);
   endfunction

   function automatic logic writes_reg(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_LD);
   endfunction

   // Issue decision, scoreboard masks and next buffer state
   always_comb begin
      state_d   = state;
      old_op    = slot1_op;
      old_des   = slot1_des;
      old_s1    = slot1_s1;
      old_s2    = slot1_s2;
      old_imm   = slot1_imm;
      set_mask  = '0;
      clr_mask  = '0;
      load_c    = 1'b0;

      if (state == ST_SLOT2) begin
         old_op  = slot2_op;
         old_des = slot2_des;
         old_s1  = slot2_s1;
         old_s2  = slot2_s2;
         old_imm = slot2_imm;
      end

      old_alu = is_alu(old_op);
      old_mem = is_mem(old_op);
      old_ill = !old_alu && !old_mem;
      old_haz = busy[old_s1] || busy[old_s2] || ((old_des != '0) && busy[old_des]);
      old_go  = (state != ST_EMPTY) && !flush &&
                (old_ill || (!old_haz && ((old_alu && alu_ready) || (old_mem && mem_ready))));

      yng_alu = is_alu(slot2_op);
      yng_mem = is_mem(slot2_op);
      yng_ill = !yng_alu && !yng_mem;
      yng_haz = busy[slot2_s1] || busy[slot2_s2] || ((slot2_des != '0) && busy[slot2_des]);
      dep_ok  = (slot1_des == '0) ||
                ((slot1_des != slot2_s1) && (slot1_des != slot2_s2) && (slot1_des != slot2_des));
      yng_go  = (state == ST_FULL) && old_go && dep_ok &&
                !(old_alu && yng_alu) && !(old_mem && yng_mem) &&
                (yng_ill || (!yng_haz && ((yng_alu && alu_ready) || (yng_mem && mem_ready))));

      alu_old_c = old_go && old_alu;
      mem_old_c = old_go && old_mem;
      alu_go_c  = alu_old_c || (yng_go && yng_alu);
      mem_go_c  = mem_old_c || (yng_go && yng_mem);
      ill_c     = (old_go && old_ill) || (yng_go && yng_ill);
      stall_c   = (state != ST_EMPTY) && !flush && !old_go;

      if (old_go && writes_reg(old_op) && (old_des != '0))
         set_mask[old_des] = 1'b1;
      if (yng_go && writes_reg(slot2_op) && (slot2_des != '0))
         set_mask[slot2_des] = 1'b1;
      if (wb0_valid)
         clr_mask[wb0_reg] = 1'b1;
      if (wb1_valid)
         clr_mask[wb1_reg] = 1'b1;
      clr_mask[0] = 1'b0;

      case (state)
         ST_EMPTY: if (in_valid) begin
            state_d = ST_FULL;
            load_c  = !flush;
         end
         ST_FULL:  if (yng_go) state_d = ST_EMPTY;
                   else if (old_go) state_d = ST_SLOT2;
         ST_SLOT2: if (old_go) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
      if (flush)
         state_d = ST_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_d;
   end

   // Pair buffer and scoreboard; set beats a same-edge writeback clear
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= '0;
         slot1_op  <= '0;
         slot1_des <= '0;
         slot1_s1  <= '0;
         slot1_s2  <= '0;
         slot1_imm <= '0;
         slot2_op  <= '0;
         slot2_des <= '0;
         slot2_s1  <= '0;
         slot2_s2  <= '0;
         slot2_imm <= '0;
      end else begin
         busy <= (busy & ~clr_mask) | set_mask;
         if (load_c) begin
            slot1_op  <= ins_1_op;
            slot1_des <= ins_1_des;
            slot1_s1  <= ins_1_s1;
            slot1_s2  <= ins_1_s2;
            slot1_imm <= ins_1_ime;
            slot2_op  <= ins_2_op;
            slot2_des <= ins_2_des;
            slot2_s1  <= ins_2_s1;
            slot2_s2  <= ins_2_s2;
            slot2_imm <= ins_2_ime;
         end
      end
   end

   // Registered issue ports; fields hold their last issued value
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready   <= 1'b1;
         alu_valid  <= 1'b0;
         alu_op     <= '0;
         alu_des    <= '0;
         alu_s1     <= '0;
         alu_s2     <= '0;
         alu_imm    <= '0;
         mem_valid  <= 1'b0;
         mem_op     <= '0;
         mem_des    <= '0;
         mem_s1     <= '0;
         mem_s2     <= '0;
         mem_imm    <= '0;
         illegal_op <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         in_ready   <= (state_d == ST_EMPTY);
         alu_valid  <= alu_go_c;
         mem_valid  <= mem_go_c;
         illegal_op <= ill_c;
         if (alu_go_c) begin
            alu_op  <= alu_old_c ? old_op  : slot2_op;
            alu_des <= alu_old_c ? old_des : slot2_des;
            alu_s1  <= alu_old_c ? old_s1  : slot2_s1;
            alu_s2  <= alu_old_c ? old_s2  : slot2_s2;
            alu_imm <= alu_old_c ? old_imm : slot2_imm;
         end
         if (mem_go_c) begin
            mem_op  <= mem_old_c ? old_op  : slot2_op;
            mem_des <= mem_old_c ? old_des : slot2_des;
            mem_s1  <= mem_old_c ? old_s1  : slot2_s1;
            mem_s2  <= mem_old_c ? old_s2  : slot2_s2;
            mem_imm <= mem_old_c ? old_imm : slot2_imm;
         end
         if (stall_c && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: single-pair vector table plus multi-cycle
// sequences, with issued instructions matched against expectation queues.
module tb_issue_ctrl;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] des;
      logic [3:0] s1;
      logic [3:0] s2;
      logic [4:0] imm;
   } ins_t;

   typedef struct packed {
      ins_t a;
      ins_t b;
      logic e1;
      logic e2;
   } vec_t;

   localparam logic [3:0] ADD = 4'b1000;
   localparam logic [3:0] BR  = 4'b0001;
   localparam logic [3:0] LD  = 4'b0100;
   localparam logic [3:0] ST  = 4'b0010;
   localparam int NV = 11;

   logic clk = 1'b0;
   logic rst, flush, in_valid, in_ready;
   logic [3:0] ins_1_op, ins_1_des, ins_1_s1, ins_1_s2;
   logic [3:0] ins_2_op, ins_2_des, ins_2_s1, ins_2_s2;
   logic [4:0] ins_1_ime, ins_2_ime;
   logic alu_ready, mem_ready, wb0_valid, wb1_valid;
   logic [3:0] wb0_reg, wb1_reg;
   logic alu_valid, mem_valid, illegal_op;
   logic [3:0] alu_op, alu_des, alu_s1, alu_s2, mem_op, mem_des, mem_s1, mem_s2;
   logic [4:0] alu_imm, mem_imm;
   logic [15:0] stall_cnt;

   ins_t alu_q[$];
   ins_t mem_q[$];
   int   ill_pending = 0;
   int   checks = 0;
   int   errors = 0;
   vec_t vt[NV];

   always #5 clk = ~clk;

   issue_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .ins_1_op(ins_1_op), .ins_1_des(ins_1_des), .ins_1_s1(ins_1_s1),
      .ins_1_s2(ins_1_s2), .ins_1_ime(ins_1_ime),
      .ins_2_op(ins_2_op), .ins_2_des(ins_2_des), .ins_2_s1(ins_2_s1),
      .ins_2_s2(ins_2_s2), .ins_2_ime(ins_2_ime),
      .alu_ready(alu_ready), .mem_ready(mem_ready),
      .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb1_valid(wb1_valid), .wb1_reg(wb1_reg),
      .alu_valid(alu_valid), .alu_op(alu_op), .alu_des(alu_des), .alu_s1(alu_s1),
      .alu_s2(alu_s2), .alu_imm(alu_imm),
      .mem_valid(mem_valid), .mem_op(mem_op), .mem_des(mem_des), .mem_s1(mem_s1),
      .mem_s2(mem_s2), .mem_imm(mem_imm),
      .illegal_op(illegal_op), .stall_cnt(stall_cnt)
   );

   function automatic ins_t mk(input logic [3:0] op, input logic [3:0] des,
                               input logic [3:0] s1, input logic [3:0] s2,
                               input logic [4:0] imm);
      ins_t r;
      r.op = op; r.des = des; r.s1 = s1; r.s2 = s2; r.imm = imm;
      return r;
   endfunction

   // 0 = ALU, 1 = MEM, 2 = illegal
   function automatic int unit_of(input logic [3:0] op);
      if (op == ADD || op == BR) return 0;
      if (op == LD || op == ST)  return 1;
      return 2;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push_ins(input ins_t x);
      if (unit_of(x.op) == 0)      alu_q.push_back(x);
      else if (unit_of(x.op) == 1) mem_q.push_back(x);
   endtask

   // Expectations for one decision cycle; two illegal slots give one pulse
   task automatic push_pair(input ins_t a, input ins_t b, input logic e1, input logic e2);
      if (e1) push_ins(a);
      if (e2) push_ins(b);
      if ((e1 && unit_of(a.op) == 2) || (e2 && unit_of(b.op) == 2)) ill_pending++;
   endtask

   task automatic check_strobes();
      ins_t got, exp;
      if (alu_valid) begin
         checks++;
         got = {alu_op, alu_des, alu_s1, alu_s2, alu_imm};
         if (alu_q.size() == 0) begin
            errors++;
            $display("FAIL alu_unexpected: got %h expected no issue", got);
         end else begin
            exp = alu_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL alu_fields: got %h expected %h", got, exp);
            end
         end
      end
      if (mem_valid) begin
         checks++;
         got = {mem_op, mem_des, mem_s1, mem_s2, mem_imm};
         if (mem_q.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected: got %h expected no issue", got);
         end else begin
            exp = mem_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL mem_fields: got %h expected %h", got, exp);
            end
         end
      end
      if (illegal_op) begin
         checks++;
         if (ill_pending == 0) begin
            errors++;
            $display("FAIL illegal_unexpected: got 1 expected 0");
         end else ill_pending--;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      check_strobes();
   endtask

   task automatic idle();
      in_valid = 1'b0; flush = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
      wb0_reg = '0; wb1_reg = '0; alu_ready = 1'b1; mem_ready = 1'b1;
   endtask

   task automatic send(input ins_t a, input ins_t b);
      ins_1_op = a.op; ins_1_des = a.des; ins_1_s1 = a.s1; ins_1_s2 = a.s2; ins_1_ime = a.imm;
      ins_2_op = b.op; ins_2_des = b.des; ins_2_s1 = b.s1; ins_2_s2 = b.s2; ins_2_ime = b.imm;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic finish_case(input string name);
      chk({name, "_drained"}, 32'(alu_q.size() + mem_q.size() + ill_pending), 32'd0);
      alu_q.delete();
      mem_q.delete();
      ill_pending = 0;
      idle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      ins_t a, b, c, d;
      logic ea, em, ei;
      idle();
      send_zero: begin
         ins_1_op = '0; ins_1_des = '0; ins_1_s1 = '0; ins_1_s2 = '0; ins_1_ime = '0;
         ins_2_op = '0; ins_2_des = '0; ins_2_s1 = '0; ins_2_s2 = '0; ins_2_ime = '0;
      end
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      chk("reset_alu_valid", 32'(alu_valid), 32'd0);
      chk("reset_mem_valid", 32'(mem_valid), 32'd0);
      chk("reset_illegal", 32'(illegal_op), 32'd0);
      chk("reset_stall", 32'(stall_cnt), 32'd0);
      chk("reset_fields", 32'({alu_op, alu_des, alu_s1, alu_s2, mem_op, mem_des, mem_s1, mem_s2}), 32'd0);
      chk("reset_imm", 32'({alu_imm, mem_imm}), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // {slot1, slot2, slot1 issues, slot2 issues alongside} from an idle start
      vt[0]  = {mk(ADD, 1, 2, 3, 0),    mk(LD, 4, 5, 0, 3),     2'b11};
      vt[1]  = {mk(ADD, 1, 2, 3, 0),    mk(ADD, 6, 1, 1, 0),    2'b10};
      vt[2]  = {mk(LD, 2, 3, 0, 1),     mk(ST, 0, 7, 2, 0),     2'b10};
      vt[3]  = {mk(BR, 0, 1, 2, 9),     mk(ST, 0, 3, 4, 1),     2'b11};
      vt[4]  = {mk(4'hF, 0, 0, 0, 0),   mk(ADD, 5, 6, 7, 2),    2'b11};
      vt[5]  = {mk(ST, 0, 1, 2, 0),     mk(LD, 3, 4, 0, 0),     2'b10};
      vt[6]  = {mk(ADD, 1, 2, 3, 0),    mk(LD, 1, 4, 0, 0),     2'b10};
      vt[7]  = {mk(LD, 2, 1, 0, 2),     mk(ADD, 3, 4, 5, 0),    2'b11};
      vt[8]  = {mk(ADD, 0, 1, 2, 0),    mk(LD, 5, 0, 0, 4),     2'b11};
      vt[9]  = {mk(4'h0, 0, 0, 0, 0),   mk(4'h3, 0, 0, 0, 0),   2'b11};
      vt[10] = {mk(ADD, 1, 2, 3, 31),   mk(4'h7, 0, 0, 0, 0),   2'b11};

      for (int i = 0; i < NV; i++) begin
         ea = (vt[i].e1 && unit_of(vt[i].a.op) == 0) || (vt[i].e2 && unit_of(vt[i].b.op) == 0);
         em = (vt[i].e1 && unit_of(vt[i].a.op) == 1) || (vt[i].e2 && unit_of(vt[i].b.op) == 1);
         ei = (vt[i].e1 && unit_of(vt[i].a.op) == 2) || (vt[i].e2 && unit_of(vt[i].b.op) == 2);
         push_pair(vt[i].a, vt[i].b, vt[i].e1, vt[i].e2);
         send(vt[i].a, vt[i].b);
         chk($sformatf("v%0d_no_early", i), 32'(alu_valid | mem_valid), 32'd0);
         cycle();
         chk($sformatf("v%0d_alu", i), 32'(alu_valid), 32'(ea));
         chk($sformatf("v%0d_mem", i), 32'(mem_valid), 32'(em));
         chk($sformatf("v%0d_ill", i), 32'(illegal_op), 32'(ei));
         finish_case($sformatf("v%0d", i));
      end

      // RAW on same unit: slot 2 waits for the writeback of r1
      a = mk(ADD, 1, 2, 3, 0); b = mk(ADD, 6, 1, 1, 0);
      push_ins(a);
      send(a, b);
      cycle();
      chk("raw_first", 32'(alu_valid), 32'd1);
      repeat (3) cycle();
      chk("raw_stall3", 32'(stall_cnt), 32'd3);
      chk("raw_in_ready_hold", 32'(in_ready), 32'd0);
      wb0_valid = 1'b1; wb0_reg = 4'd1;
      cycle();
      wb0_valid = 1'b0;
      chk("raw_wb_cycle", 32'(alu_valid), 32'd0);
      chk("raw_stall4", 32'(stall_cnt), 32'd4);
      push_ins(b);
      cycle();
      chk("raw_second", 32'(alu_valid), 32'd1);
      chk("raw_stall_kept", 32'(stall_cnt), 32'd4);
      chk("raw_in_ready", 32'(in_ready), 32'd1);
      finish_case("raw");

      // load r2 then dependent store on the other unit
      a = mk(LD, 2, 3, 0, 1); b = mk(ST, 0, 7, 2, 0);
      push_ins(a);
      send(a, b);
      cycle();
      chk("ldst_load", 32'({alu_valid, mem_valid}), 32'd1);
      repeat (2) cycle();
      chk("ldst_stall2", 32'(stall_cnt), 32'd2);
      wb1_valid = 1'b1; wb1_reg = 4'd2;
      cycle();
      wb1_valid = 1'b0;
      chk("ldst_stall3", 32'(stall_cnt), 32'd3);
      push_ins(b);
      cycle();
      chk("ldst_store", 32'(mem_valid), 32'd1);
      chk("ldst_stall_final", 32'(stall_cnt), 32'd3);
      finish_case("ldst");

      // MEM back-pressure holds the independent ALU op behind it
      mem_ready = 1'b0;
      a = mk(LD, 4, 5, 0, 3); b = mk(ADD, 8, 9, 10, 0);
      send(a, b);
      repeat (3) cycle();
      chk("bp_no_alu", 32'(alu_valid), 32'd0);
      chk("bp_stall3", 32'(stall_cnt), 32'd3);
      mem_ready = 1'b1;
      push_pair(a, b, 1'b1, 1'b1);
      cycle();
      chk("bp_both", 32'({alu_valid, mem_valid}), 32'd3);
      finish_case("bp");

      // busy set by issue, cleared by both writeback ports
      a = mk(ADD, 1, 2, 3, 0); b = mk(LD, 4, 5, 0, 3);
      push_pair(a, b, 1'b1, 1'b1);
      send(a, b);
      cycle();
      chk("sb_pair", 32'({alu_valid, mem_valid}), 32'd3);
      c = mk(ADD, 8, 4, 0, 0); d = mk(ST, 0, 1, 0, 2);
      send(c, d);
      cycle();
      chk("sb_blocked", 32'({alu_valid, mem_valid}), 32'd0);
      wb0_valid = 1'b1; wb0_reg = 4'd4; wb1_valid = 1'b1; wb1_reg = 4'd1;
      cycle();
      wb0_valid = 1'b0; wb1_valid = 1'b0;
      chk("sb_stall2", 32'(stall_cnt), 32'd2);
      push_pair(c, d, 1'b1, 1'b1);
      cycle();
      chk("sb_released", 32'({alu_valid, mem_valid}), 32'd3);
      finish_case("sb");

      // set and clear of r3 on the same edge leaves r3 busy
      a = mk(ADD, 3, 0, 0, 0); b = mk(ST, 0, 0, 0, 0);
      push_pair(a, b, 1'b1, 1'b1);
      send(a, b);
      wb0_valid = 1'b1; wb0_reg = 4'd3;
      cycle();
      wb0_valid = 1'b0;
      chk("setwin_issue", 32'({alu_valid, mem_valid}), 32'd3);
      c = mk(ADD, 5, 3, 0, 0); d = mk(ST, 0, 0, 0, 1);
      send(c, d);
      cycle();
      chk("setwin_blocked", 32'(alu_valid), 32'd0);
      wb0_valid = 1'b1; wb0_reg = 4'd3;
      cycle();
      wb0_valid = 1'b0;
      push_pair(c, d, 1'b1, 1'b1);
      cycle();
      chk("setwin_released", 32'({alu_valid, mem_valid}), 32'd3);
      finish_case("setwin");

      // flush while FULL discards the pair without touching busy
      alu_ready = 1'b0; mem_ready = 1'b0;
      a = mk(ADD, 1, 2, 3, 0); b = mk(LD, 4, 5, 0, 0);
      send(a, b);
      flush = 1'b1;
      cycle();
      flush = 1'b0; alu_ready = 1'b1; mem_ready = 1'b1;
      chk("flush_stall", 32'(stall_cnt), 32'd0);
      cycle();
      chk("flush_no_issue", 32'({alu_valid, mem_valid}), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      c = mk(ADD, 7, 1, 4, 0); d = mk(ST, 0, 4, 1, 0);
      push_pair(c, d, 1'b1, 1'b1);
      send(c, d);
      cycle();
      chk("flush_after", 32'({alu_valid, mem_valid}), 32'd3);
      finish_case("flush");

      // rst with r5 busy and a pair stalled, then rst over an issuing pair
      a = mk(ADD, 5, 0, 0, 0); b = mk(ST, 0, 0, 0, 0);
      push_pair(a, b, 1'b1, 1'b1);
      send(a, b);
      cycle();
      c = mk(LD, 2, 5, 0, 0); d = mk(ADD, 9, 0, 0, 0);
      send(c, d);
      cycle();
      chk("rst_pre_stall", 32'(stall_cnt), 32'd1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_strobes", 32'({alu_valid, mem_valid, illegal_op}), 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      a = mk(ADD, 6, 5, 5, 0); b = mk(LD, 3, 5, 0, 0);
      push_pair(a, b, 1'b1, 1'b1);
      send(a, b);
      cycle();
      chk("rst_busy_clear", 32'({alu_valid, mem_valid}), 32'd3);
      c = mk(BR, 0, 1, 1, 0); d = mk(LD, 7, 0, 0, 0);
      send(c, d);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_drop_inflight", 32'({alu_valid, mem_valid}), 32'd0);
      finish_case("rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
